// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit: operation codes
// presented by EXE, controller state encoding, the iteration count and the
// data width used by the shift datapath.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    // Operation codes carried on the 3-bit op port.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    // Two's-complement magnitude when the operand is to be treated as signed.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic             isSigned);
        return (isSigned && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Shared radix-2 shift datapath for multiply and divide. A 64-bit register
// holds {upper, lower}; one step is taken per cycle while en_i is high.
//   Multiply: lower starts as the multiplier, the held operand is the
//             multiplicand; after 32 steps the register is the product.
//   Divide:   lower starts as the dividend, the held operand is the divisor;
//             restoring steps leave {remainder, quotient}.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load_i        capture low_i/opnd_i/divMode_i and clear the upper half
//   en_i          perform one iteration step
//   divMode_i     1 = divide, 0 = multiply (latched on load_i)
//   low_i         initial lower half (multiplier or dividend magnitude)
//   opnd_i        held operand (multiplicand or divisor magnitude)
//   acc_o         current 64-bit register contents
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              divMode_i,
    input  logic [XLEN-1:0]   low_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   opnd_q;
    logic              divMode_q;

    logic [XLEN:0]     addSum;
    logic [XLEN:0]     remShift;
    logic              remGeq;
    logic [XLEN-1:0]   remDiff;

    // One iteration step. The multiply path adds the multiplicand into the
    // upper half when the current multiplier bit is set, then shifts the
    // whole register right, keeping the carry. The divide path shifts the
    // next dividend bit into a 33-bit partial remainder and subtracts the
    // divisor when it fits. A successful subtraction always leaves a value
    // below the divisor, so 32 bits of difference are enough.
    always_comb begin
        acc_d    = acc_q;
        addSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        remShift = acc_q[2*XLEN-1:XLEN-1];
        remGeq   = (remShift >= {1'b0, opnd_q});
        remDiff  = remShift[XLEN-1:0] - opnd_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, low_i};
        end else if (en_i) begin
            if (divMode_q) begin
                if (remGeq) begin
                    acc_d = {remDiff, acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {remShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {addSum, acc_q[XLEN-1:1]};
            end
        end
    end

    // Register update; the operand and mode stay fixed for the whole run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            divMode_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opnd_q    <= opnd_i;
                divMode_q <= divMode_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Owns the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from
// EXE, runs mul/div on the shared muldiv_iter datapath for 32 cycles plus a
// sign fix-up cycle, and stalls ID/EXE while an operation is in flight.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   op_valid, op       HI/LO-writing instruction in EXE and its opcode
//   rs_data, rt_data   operands
//   mfhl_req           MFHI/MFLO in EXE
//   flush              cancel the in-flight operation
//   busy               registered, high while not idle
//   stall              combinational busy & (op_valid | mfhl_req)
//   done               registered one-cycle pulse when a result lands
//   hi, lo             registered HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mfhl_req,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    muldiv_state_e     state_q;
    logic [CNT_W-1:0]  count_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;
    logic              isDiv_q;
    logic              negRes_q;
    logic              remNeg_q;
    logic              divZero_q;

    logic              accept;
    logic              isSignedOp;
    logic              isDivOp;
    logic              isMulDivOp;
    logic [XLEN-1:0]   rsMag;
    logic [XLEN-1:0]   rtMag;
    logic [XLEN-1:0]   iterLow;
    logic [XLEN-1:0]   iterOpnd;
    logic [2*XLEN-1:0] acc;

    logic [2*XLEN-1:0] prodFix_d;
    logic [XLEN-1:0]   quotFix_d;
    logic [XLEN-1:0]   remFix_d;

    // Decode the incoming opcode and prepare operand magnitudes. For a
    // multiply the multiplier (rt) goes in the shifting lower half; for a
    // divide the dividend (rs) does and the divisor is held.
    always_comb begin
        isSignedOp = (op == OP_MULT) || (op == OP_DIV);
        isDivOp    = (op == OP_DIV)  || (op == OP_DIVU);
        isMulDivOp = (op == OP_MULT) || (op == OP_MULTU) || isDivOp;
        rsMag      = magnitude(rs_data, isSignedOp);
        rtMag      = magnitude(rt_data, isSignedOp);
        iterLow    = isDivOp ? rsMag : rtMag;
        iterOpnd   = isDivOp ? rtMag : rsMag;
    end

    assign accept = op_valid & ~flush & (state_q == ST_IDLE);

    muldiv_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept & isMulDivOp),
        .en_i      (state_q == ST_CALC),
        .divMode_i (isDivOp),
        .low_i     (iterLow),
        .opnd_i    (iterOpnd),
        .acc_o     (acc)
    );

    // Sign fix-up of the raw magnitude result. On divide-by-zero the
    // quotient is forced to all ones; the restoring loop leaves the dividend
    // magnitude as remainder, and re-applying the dividend sign gives back
    // rs_data exactly, so HI needs no separate copy of the operand.
    always_comb begin
        prodFix_d = negRes_q ? -acc : acc;
        quotFix_d = divZero_q ? {XLEN{1'b1}}
                              : (negRes_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        remFix_d  = remNeg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    // Controller FSM with registered busy/done and HI/LO. flush cancels any
    // busy state without touching HI/LO; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi_q <= rs_data;
                        end else if (op == OP_MTLO) begin
                            lo_q <= rs_data;
                        end else if (isMulDivOp) begin
                            state_q   <= ST_CALC;
                            busy_q    <= 1'b1;
                            count_q   <= CNT_W'(ITER - 1);
                            isDiv_q   <= isDivOp;
                            negRes_q  <= isSignedOp & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                            remNeg_q  <= isSignedOp & isDivOp & rs_data[XLEN-1];
                            divZero_q <= isDivOp & (rt_data == '0);
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (count_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (isDiv_q) begin
                            hi_q <= remFix_d;
                            lo_q <= quotFix_d;
                        end else begin
                            hi_q <= prodFix_d[2*XLEN-1:XLEN];
                            lo_q <= prodFix_d[XLEN-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (op_valid | mfhl_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// latency/arithmetic model of HI/LO.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mfhl_req = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    bit          mBusy = 1'b0;
    bit          mDone = 1'b0;
    int          mCnt = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [63:0] mPend = '0;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .mfhl_req (mfhl_req),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {hi, lo} of a mul/div computed with plain
    // 64-bit arithmetic; SV division truncates toward zero and gives the
    // remainder the dividend's sign, matching MIPS.
    function automatic logic [63:0] refResult(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = '0;
        if (o == OP_MULT) begin
            res = sa * sb;
        end else if (o == OP_MULTU) begin
            res = ua * ub;
        end else if (o == OP_DIV || o == OP_DIVU) begin
            if (b == 32'd0) begin
                res = {a, 32'hFFFF_FFFF};
            end else if (o == OP_DIV) begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end else begin
                q   = ua / ub;
                r   = ua % ub;
                res = {r[31:0], q[31:0]};
            end
        end
        return res;
    endfunction

    // Model: an accepted mul/div makes the unit busy for 33 cycles, after
    // which HI/LO take the arithmetic result and done pulses once.
    always @(posedge clk) begin
        if (!rst) begin
            mBusy <= 1'b0;
            mCnt  <= 0;
            mHi   <= '0;
            mLo   <= '0;
            mDone <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mBusy) begin
                if (flush) begin
                    mBusy <= 1'b0;
                    mCnt  <= 0;
                end else if (mCnt == 1) begin
                    mBusy <= 1'b0;
                    mCnt  <= 0;
                    mHi   <= mPend[63:32];
                    mLo   <= mPend[31:0];
                    mDone <= 1'b1;
                end else begin
                    mCnt <= mCnt - 1;
                end
            end else if (op_valid && !flush) begin
                if (op == OP_MTHI) begin
                    mHi <= rs_data;
                end else if (op == OP_MTLO) begin
                    mLo <= rs_data;
                end else if (op <= OP_DIVU) begin
                    mPend <= refResult(op, rs_data, rt_data);
                    mBusy <= 1'b1;
                    mCnt  <= 33;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_busy",  busy,  mBusy);
            checkOutput("cyc_done",  done,  mDone);
            checkOutput("cyc_hi",    hi,    mHi);
            checkOutput("cyc_lo",    lo,    mLo);
            checkOutput("cyc_stall", stall, mBusy & (op_valid | mfhl_req));
        end
    end

    task automatic applyStimulus(input bit v, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input bit m, input bit f);
        @(negedge clk);
        #1;
        op_valid = v;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        mfhl_req = m;
        flush    = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int doneSeen;
        int lastChecks;

        $display("[TB] starting muldiv_ctrl bench");
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_hi",   hi,   32'd0);
        checkOutput("rst_lo",   lo,   32'd0);
        checkEn = 1'b1;
        rst = 1'b1;

        checkOutput("ref_mult", refResult(OP_MULT, 32'hFFFF_FFFE, 32'd7), 64'hFFFF_FFFF_FFFF_FFF2);
        checkOutput("ref_div",  refResult(OP_DIV, 32'hFFFF_FFF9, 32'd2),  64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("ref_divu", refResult(OP_DIVU, 32'd7, 32'd2),         64'h0000_0001_0000_0003);
        checkOutput("ref_div0", refResult(OP_DIVU, 32'h1234, 32'd0),      64'h0000_1234_FFFF_FFFF);
        checkOutput("ref_ovf",  refResult(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        // MULT -2 * 7 with busy window and done pulse
        applyStimulus(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd7, 1'b0, 1'b0);
        idle(1);
        #1 checkOutput("mult_busy_c1", busy, 1'b1);
        idle(32);
        #1 checkOutput("mult_busy_c33", busy, 1'b1);
        checkOutput("mult_done_c33", done, 1'b0);
        idle(1);
        #1 checkOutput("mult_busy_c34", busy, 1'b0);
        checkOutput("mult_done_c34", done, 1'b1);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFF2);
        idle(1);
        #1 checkOutput("mult_done_c35", done, 1'b0);

        // Divide cases
        applyStimulus(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(34);
        #1 checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        applyStimulus(1'b1, OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(34);
        #1 checkOutput("divu_hi", hi, 32'd1);
        checkOutput("divu_lo", lo, 32'd3);
        applyStimulus(1'b1, OP_DIVU, 32'h1234, 32'd0, 1'b0, 1'b0);
        idle(34);
        #1 checkOutput("div0_hi", hi, 32'h1234);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        applyStimulus(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(34);
        #1 checkOutput("ovf_hi", hi, 32'd0);
        checkOutput("ovf_lo", lo, 32'h8000_0000);

        // Back-to-back: second op issued in the cycle the first completes
        applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);
        idle(33);
        applyStimulus(1'b1, OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
        #1 checkOutput("b2b_first_lo", lo, 32'd15);
        idle(34);
        #1 checkOutput("b2b_second_lo", lo, 32'd42);

        // Stall while busy, held MTLO accepted once busy falls
        applyStimulus(1'b1, OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
        idle(9);
        for (int c = 10; c <= 34; c++) begin
            applyStimulus(1'b1, OP_MTLO, 32'hA5A5_0001, 32'd0, 1'b1, 1'b0);
            #1;
            if (c == 10 || c == 33 || c == 34)
                checkOutput($sformatf("stall_c%0d", c), stall, (c <= 33) ? 1'b1 : 1'b0);
        end
        checkOutput("stall_hi_c34", hi, 32'd1);
        checkOutput("stall_lo_c34", lo, 32'd0);
        idle(1);
        #1 checkOutput("mtlo_lo_c35", lo, 32'hA5A5_0001);

        // Flush mid-divide: HI/LO untouched, no done
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(19);
        applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b1);
        #1 checkOutput("flush_busy_c20", busy, 1'b1);
        idle(1);
        #1 checkOutput("flush_busy_c21", busy, 1'b0);
        checkOutput("flush_hi", hi, 32'd1);
        checkOutput("flush_lo", lo, 32'hA5A5_0001);
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            #1 if (done) doneSeen++;
        end
        checkOutput("flush_no_done", doneSeen, 0);

        // Flush in IDLE blocks an MTHI
        applyStimulus(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        idle(1);
        #1 checkOutput("idle_flush_hi", hi, 32'd1);

        // Reset in the middle of a MULT
        applyStimulus(1'b1, OP_MULT, 32'd123, 32'd456, 1'b0, 1'b0);
        idle(14);
        idle(1);
        rst = 1'b0;
        idle(1);
        #1 checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        rst = 1'b1;

        // Randomized traffic checked by the per-cycle compare
        lastChecks = checks;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 3) == 0, 3'($urandom_range(0, 5)), pickOperand(),
                          pickOperand(), ($urandom % 8) == 0, ($urandom % 97) == 0);
        end
        idle(40);
        checkOutput("random_ran", (checks > lastChecks + 10000) ? 1'b1 : 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
